// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared pipeline constants, forwarding selects and stage-shadow types
package fwd_hazard_unit_pkg;
  localparam int REG_BITS = 5;
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_WB = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  typedef struct packed {
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic uses_rs;
    logic uses_rt;
    logic [REG_BITS-1:0] dest;
    logic reg_write;
    logic mem_read;
  } stage_t;
  typedef struct packed {
    logic [REG_BITS-1:0] dest;
    logic reg_write;
  } wr_t;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-stage decode inputs and forwarding/stall outputs of the hazard unit
interface fwd_hazard_unit_if import fwd_hazard_unit_pkg::*; #(parameter int CNT_BITS = 16);
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic [REG_BITS-1:0] id_dest;
  logic id_uses_rs;
  logic id_uses_rt;
  logic id_reg_write;
  logic id_mem_read;
  logic flush;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic pc_write;
  logic ifid_write;
  logic stall;
  logic [CNT_BITS-1:0] stall_count;
  modport master (
    output id_rs, id_rt, id_dest, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush,
    input forward_a, forward_b, pc_write, ifid_write, stall, stall_count
  );
  modport slave (
    input id_rs, id_rt, id_dest, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush,
    output forward_a, forward_b, pc_write, ifid_write, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_select.sv
// fwd_select: per-operand forwarding comparator, MEM result wins over WB, register 0 never forwarded
module fwd_select import fwd_hazard_unit_pkg::*; (
  input  logic [REG_BITS-1:0] i_src,
  input  logic                i_uses,
  input  wr_t                 i_mem,
  input  wr_t                 i_wb,
  output logic [1:0]          o_sel
);
  logic w_live;
  assign w_live = i_uses && (i_src != '0);
  assign o_sel = !w_live ? FWD_REGFILE :
                 (i_mem.reg_write && i_mem.dest == i_src) ? FWD_MEM :
                 (i_wb.reg_write && i_wb.dest == i_src) ? FWD_WB : FWD_REGFILE;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects and one-cycle load-use stall control
module fwd_hazard_unit import fwd_hazard_unit_pkg::*; #(
  parameter int CNT_BITS = 16
) (
  input logic clk,
  input logic reset,
  fwd_hazard_unit_if.slave bus
);
  stage_t r_ex;
  wr_t r_mem;
  wr_t r_wb;
  logic [CNT_BITS-1:0] r_cnt;
  logic w_hit_rs;
  logic w_hit_rt;
  logic w_load_use;
  logic w_stall;
  fwd_select u_fwd_a (
    .i_src (r_ex.rs),
    .i_uses(r_ex.uses_rs),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (bus.forward_a)
  );
  fwd_select u_fwd_b (
    .i_src (r_ex.rt),
    .i_uses(r_ex.uses_rt),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (bus.forward_b)
  );
  assign w_hit_rs = bus.id_uses_rs && bus.id_rs == r_ex.dest;
  assign w_hit_rt = bus.id_uses_rt && bus.id_rt == r_ex.dest;
  assign w_load_use = r_ex.mem_read && r_ex.reg_write && r_ex.dest != '0 && (w_hit_rs || w_hit_rt);
  // a taken branch squashes the consumer anyway, so it cancels the bubble request
  assign w_stall = w_load_use && !bus.flush;
  assign bus.stall = w_stall;
  assign bus.pc_write = !w_stall;
  assign bus.ifid_write = !w_stall;
  assign bus.stall_count = r_cnt;
  // advance stage shadows, injecting a bubble into EX on stall or flush; count stalls with saturation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex <= '0;
      r_mem <= '0;
      r_wb <= '0;
      r_cnt <= '0;
    end else begin
      r_wb <= r_mem;
      r_mem <= '{dest: r_ex.dest, reg_write: r_ex.reg_write};
      r_ex <= (w_stall || bus.flush) ? '0 : '{rs: bus.id_rs, rt: bus.id_rt, uses_rs: bus.id_uses_rs,
              uses_rt: bus.id_uses_rt, dest: bus.id_dest, reg_write: bus.id_reg_write,
              mem_read: bus.id_mem_read};
      if (w_stall && r_cnt != '1) r_cnt <= r_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench with an in-flight instruction model of the hazard unit
module tb_fwd_hazard_unit;
  import fwd_hazard_unit_pkg::*;
  localparam int CB = 2;
  localparam int CMAX = (1 << CB) - 1;
  typedef struct {
    int rs;
    int rt;
    bit ur;
    bit ut;
    int dest;
    bit rw;
    bit mr;
  } ins_t;
  typedef struct {
    bit chk;
    int fa;
    int fb;
    bit st;
    bit pw;
    bit iw;
    int cnt;
  } exp_t;
  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;
  fwd_hazard_unit_if #(.CNT_BITS(CB)) bus();
  fwd_hazard_unit #(.CNT_BITS(CB)) dut (.clk(clk), .reset(reset), .bus(bus));
  exp_t sbq[$];
  ins_t hist[$];
  ins_t bub;
  int cnt = 0;
  bit known = 0;
  bit held = 0;
  int total = 0;
  int bad = 0;
  function automatic ins_t mk(int rs, int rt, bit ur, bit ut, int dest, bit rw, bit mr);
    ins_t i;
    i.rs = rs; i.rt = rt; i.ur = ur; i.ut = ut; i.dest = dest; i.rw = rw; i.mr = mr;
    return i;
  endfunction
  function automatic int fsel(int r, bit u);
    if (!u || r == 0) return 0;
    for (int d = 1; d <= 2; d++)
      if (hist[d].rw && hist[d].dest == r) return d == 1 ? 2 : 1;
    return 0;
  endfunction
  task automatic step(ins_t i, bit fl, bit rs_);
    exp_t e;
    ins_t ld;
    bit st;
    bus.id_rs = REG_BITS'(i.rs);
    bus.id_rt = REG_BITS'(i.rt);
    bus.id_uses_rs = i.ur;
    bus.id_uses_rt = i.ut;
    bus.id_dest = REG_BITS'(i.dest);
    bus.id_reg_write = i.rw;
    bus.id_mem_read = i.mr;
    bus.flush = fl;
    reset = rs_;
    ld = hist[0];
    st = ld.mr && ld.rw && ld.dest != 0 && ((i.ur && i.rs == ld.dest) || (i.ut && i.rt == ld.dest)) && !fl;
    e.chk = known;
    e.fa = fsel(hist[0].rs, hist[0].ur);
    e.fb = fsel(hist[0].rt, hist[0].ut);
    e.st = st;
    e.pw = !st;
    e.iw = !st;
    e.cnt = cnt;
    sbq.push_back(e);
    @(posedge clk);
    if (rs_) begin
      hist = '{bub, bub, bub};
      cnt = 0;
      known = 1;
    end else begin
      if (st && cnt < CMAX) cnt++;
      hist.push_front((st || fl) ? bub : i);
      void'(hist.pop_back());
    end
    held = st && !rs_;
    #1;
  endtask
  task automatic cmp(string n, logic [31:0] a, logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, x, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          cmp("forward_a", 32'(bus.forward_a), 32'(e.fa));
          cmp("forward_b", 32'(bus.forward_b), 32'(e.fb));
          cmp("stall", 32'(bus.stall), 32'(e.st));
          cmp("pc_write", 32'(bus.pc_write), 32'(e.pw));
          cmp("ifid_write", 32'(bus.ifid_write), 32'(e.iw));
          cmp("stall_count", 32'(bus.stall_count), 32'(e.cnt));
        end
      end
    end
  end
  initial begin
    ins_t nop, cur, lw, use2;
    bub = mk(0, 0, 0, 0, 0, 0, 0);
    nop = bub;
    hist = '{bub, bub, bub};
    @(posedge clk);
    #1;
    step(nop, 0, 1);
    step(nop, 0, 1);
    step(nop, 0, 0);
    step(mk(1, 2, 1, 1, 3, 1, 0), 0, 0);
    step(mk(3, 5, 1, 1, 4, 1, 0), 0, 0);
    step(nop, 0, 0);
    step(nop, 0, 0);
    step(mk(1, 2, 1, 1, 3, 1, 0), 0, 0);
    step(mk(4, 5, 1, 1, 3, 1, 0), 0, 0);
    step(mk(6, 3, 1, 1, 7, 1, 0), 0, 0);
    step(nop, 0, 0);
    step(nop, 0, 0);
    step(mk(1, 2, 1, 1, 0, 1, 1), 0, 0);
    step(mk(0, 0, 1, 1, 5, 1, 0), 0, 0);
    step(nop, 0, 0);
    step(nop, 0, 0);
    lw = mk(1, 0, 1, 0, 2, 1, 1);
    use2 = mk(2, 2, 1, 1, 4, 1, 0);
    step(lw, 0, 0);
    step(use2, 0, 0);
    step(use2, 0, 0);
    step(nop, 0, 0);
    step(nop, 0, 0);
    step(lw, 0, 0);
    step(use2, 1, 0);
    step(nop, 0, 0);
    step(nop, 0, 0);
    step(lw, 0, 0);
    step(use2, 0, 1);
    step(nop, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(lw, 0, 0);
      step(use2, 0, 0);
      step(use2, 0, 0);
    end
    step(nop, 0, 0);
    cur = nop;
    for (int k = 0; k < 400; k++) begin
      if (!held)
        cur = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0));
      step(cur, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    step(nop, 0, 0);
    @(posedge clk);
    @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
